// File: rtl/lc3b_agu_mem_pkg.sv
// Shared definitions for the LC-3b address-generation / data-memory stage:
// controller state encoding, response fault codes and a byte sign-extend helper.
package lc3b_agu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_MEM  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] FAULT_OK      = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/lc3b_mem_lane.sv
// Byte-lane steering for the data-memory port: store mask/data replication
// and load byte select with sign extension (little-endian, ea[0] picks lane).
module lc3b_mem_lane
  import lc3b_agu_mem_pkg::*;
(
  input  logic        i_ea0,
  input  logic        i_word,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_wmask,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);

  always_comb begin
    o_wmask = 2'b11;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (!i_word) begin
      o_wmask = i_ea0 ? 2'b10 : 2'b01;
      o_wdata = {i_wdata[7:0], i_wdata[7:0]};
      o_rdata = sext8(i_ea0 ? i_rdata[15:8] : i_rdata[7:0]);
    end
  end

endmodule

// File: rtl/lc3b_agu_mem.sv
// LC-3b effective-address and data-memory access stage for LDB/LDW/STB/STW:
// one transaction at a time through IDLE -> ADDR -> MEM -> RESP.
module lc3b_agu_mem
  import lc3b_agu_mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] base,
  input  logic [15:0] offset,
  input  logic        shift_en,
  input  logic        word,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_fault
);

  localparam int CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic signed [15:0] r_base;
  logic signed [15:0] r_off;
  logic               r_shift;
  logic               r_word;
  logic               r_we;
  logic        [15:0] r_wdata;
  logic        [15:0] r_ea;
  logic        [15:0] r_data;
  logic        [1:0]  r_fault;

  logic signed [15:0] w_off_sh;
  logic signed [15:0] w_ea;
  logic               w_accept;
  logic               w_misalign;
  logic               w_timeout;
  logic        [1:0]  w_lane_mask;
  logic        [15:0] w_lane_wdata;
  logic        [15:0] w_lane_rdata;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_off_sh   = r_shift ? {r_off[14:0], 1'b0} : r_off;
  // Carry out of the 16-bit add is dropped: addresses wrap around 0xFFFF.
  assign w_ea       = r_base + w_off_sh;
  assign w_misalign = r_word && w_ea[0];

  lc3b_mem_lane u_lane (
    .i_ea0   (r_ea[0]),
    .i_word  (r_word),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_wmask (w_lane_mask),
    .o_wdata (w_lane_wdata),
    .o_rdata (w_lane_rdata)
  );

  generate
    if (MEM_TIMEOUT != 0) begin : g_tmo
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n || (r_state != ST_MEM)) r_cnt <= '0;
        else                               r_cnt <= r_cnt + CNT_W'(1);
      end

      assign w_timeout = (r_state == ST_MEM) && !mem_r &&
                         (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_tmo
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = ST_ADDR;
      ST_ADDR: w_state_nxt = w_misalign ? ST_RESP : ST_MEM;
      ST_MEM:  if (mem_r || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers carry no reset; every output below is gated by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base  <= base;
      r_off   <= offset;
      r_shift <= shift_en;
      r_word  <= word;
      r_we    <= we;
      r_wdata <= wdata;
    end
    if (r_state == ST_ADDR) begin
      r_ea    <= w_ea;
      r_data  <= '0;
      r_fault <= w_misalign ? FAULT_ALIGN : FAULT_OK;
    end
    if (r_state == ST_MEM) begin
      if (mem_r) begin
        r_data  <= r_we ? 16'h0000 : w_lane_rdata;
        r_fault <= FAULT_OK;
      end else if (w_timeout) begin
        r_data  <= '0;
        r_fault <= FAULT_TIMEOUT;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_en     = (r_state == ST_MEM);
  assign mem_we     = mem_en && r_we;
  assign mem_addr   = mem_en ? {r_ea[15:1], 1'b0} : 16'h0000;
  assign mem_wdata  = mem_en ? w_lane_wdata : 16'h0000;
  assign mem_wmask  = mem_en ? w_lane_mask : 2'b00;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = resp_valid ? r_data : 16'h0000;
  assign resp_fault = resp_valid ? r_fault : 2'b00;

endmodule

// File: tb/tb_lc3b_agu_mem.sv
// Bench for lc3b_agu_mem: directed vector table, hand-written reset/stall/timeout
// sequences, and randomized traffic against a byte-addressed memory model.
module tb_lc3b_agu_mem;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, shift_en, word, we;
  logic        mem_en, mem_we, mem_r, resp_valid, resp_ready;
  logic [15:0] base, offset, wdata, mem_addr, mem_wdata, mem_rdata, resp_data;
  logic [1:0]  mem_wmask, resp_fault;

  always #5 clk = ~clk;

  lc3b_agu_mem #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .base       (base),
    .offset     (offset),
    .shift_en   (shift_en),
    .word       (word),
    .we         (we),
    .wdata      (wdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .mem_r      (mem_r),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault)
  );

  logic [7:0] bus_mem [0:65535];
  logic [7:0] mdl_mem [0:65535];

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] ob_addr, ob_wdata, ob_data;
  logic [1:0]  ob_mask, ob_fault;
  logic        ob_we, ob_unstable;
  int          ob_lat, ob_mcyc;

  typedef struct {
    logic [15:0] b;
    logic [15:0] o;
    logic        sh;
    logic        wd;
    logic        w;
    logic [15:0] wdt;
    int          dly;
    logic        e_mem;
    logic [15:0] e_addr;
    logic [1:0]  e_mask;
    logic [15:0] e_wdata;
    logic [15:0] e_data;
    logic [1:0]  e_fault;
    int          e_lat;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bus_mem[a] = d;
    mdl_mem[a] = d;
  endtask

  // Reference: little-endian byte memory, EA arithmetic mod 2^16.
  task automatic model(input logic [15:0] b, input logic [15:0] o, input logic sh,
                       input logic wd, input logic w, input logic [15:0] wdt, input int dly,
                       output logic e_mem, output logic [15:0] e_addr, output logic [1:0] e_mask,
                       output logic [15:0] e_wdata, output logic [15:0] e_data,
                       output logic [1:0] e_fault, output int e_lat);
    int ea;
    ea      = (int'(b) + (sh ? 2 * int'(o) : int'(o))) % 65536;
    e_mem   = 1'b1;
    e_addr  = 16'(ea & 'hFFFE);
    e_mask  = wd ? 2'b11 : ((ea % 2 == 1) ? 2'b10 : 2'b01);
    e_wdata = wd ? wdt : {wdt[7:0], wdt[7:0]};
    e_data  = 16'h0000;
    e_fault = 2'b00;
    if (wd && (ea % 2 == 1)) begin
      e_mem   = 1'b0;
      e_fault = 2'b01;
      e_lat   = 2;
    end else if (dly >= TMO) begin
      e_fault = 2'b10;
      e_lat   = 2 + TMO;
    end else begin
      e_lat = 3 + dly;
      if (w) begin
        if (wd) begin
          mdl_mem[ea]     = wdt[7:0];
          mdl_mem[ea + 1] = wdt[15:8];
        end else begin
          mdl_mem[ea] = wdt[7:0];
        end
      end else if (wd) begin
        e_data = {mdl_mem[ea + 1], mdl_mem[ea]};
      end else begin
        e_data = {{8{mdl_mem[ea][7]}}, mdl_mem[ea]};
      end
    end
  endtask

  // Issue one request and act as the memory until resp_valid rises.
  task automatic run_txn(input logic [15:0] b, input logic [15:0] o, input logic sh,
                         input logic wd, input logic w, input logic [15:0] wdt, input int dly);
    int guard;
    ob_mcyc = 0; ob_unstable = 1'b0; ob_lat = 0;
    ob_addr = '0; ob_mask = '0; ob_wdata = '0; ob_we = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    base = b; offset = o; shift_en = sh; word = wd; we = w; wdata = wdt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ob_lat = 1;
    while (!resp_valid && ob_lat < 40) begin
      mem_r = 1'b0;
      mem_rdata = 16'h0000;
      if (mem_en) begin
        if (ob_mcyc == 0) begin
          ob_addr = mem_addr; ob_mask = mem_wmask; ob_wdata = mem_wdata; ob_we = mem_we;
        end else if (mem_addr !== ob_addr || mem_wmask !== ob_mask ||
                     mem_wdata !== ob_wdata || mem_we !== ob_we) begin
          ob_unstable = 1'b1;
        end
        if (ob_mcyc == dly) begin
          mem_r = 1'b1;
          mem_rdata = {bus_mem[{mem_addr[15:1], 1'b1}], bus_mem[{mem_addr[15:1], 1'b0}]};
          if (mem_we) begin
            if (mem_wmask[0]) bus_mem[{mem_addr[15:1], 1'b0}] = mem_wdata[7:0];
            if (mem_wmask[1]) bus_mem[{mem_addr[15:1], 1'b1}] = mem_wdata[15:8];
          end
        end
        ob_mcyc++;
      end
      tick();
      mem_r = 1'b0;
      ob_lat++;
    end
    chk("resp_valid_within_budget", resp_valid, 1'b1);
    ob_data  = resp_data;
    ob_fault = resp_fault;
  endtask

  task automatic finish_resp(input string tag, input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      chk({tag, ".hold"}, {resp_valid, req_ready, resp_fault, resp_data},
          {1'b1, 1'b0, ob_fault, ob_data});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, ".handshake"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic compare_obs(input string tag, input logic e_mem, input logic [15:0] e_addr,
                             input logic [1:0] e_mask, input logic [15:0] e_wdata, input logic e_we,
                             input logic [15:0] e_data, input logic [1:0] e_fault, input int e_lat);
    chk({tag, ".data"}, ob_data, e_data);
    chk({tag, ".fault"}, ob_fault, e_fault);
    chk({tag, ".latency"}, ob_lat, e_lat);
    if (e_mem) begin
      chk({tag, ".mem_addr"}, ob_addr, e_addr);
      chk({tag, ".mem_wmask"}, ob_mask, e_mask);
      chk({tag, ".mem_wdata"}, ob_wdata, e_wdata);
      chk({tag, ".mem_we"}, ob_we, e_we);
      chk({tag, ".mem_stable"}, ob_unstable, 1'b0);
    end else begin
      chk({tag, ".no_mem_en"}, ob_mcyc, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_mem, seen;
    logic [15:0] e_addr, e_wdata, e_data, rb, ro, rwdt;
    logic [1:0]  e_mask, e_fault;
    logic        rsh, rwd, rw;
    int          e_lat, rdly;
    string       tag;

    rst_n = 1'b0; req_valid = 1'b0; base = '0; offset = '0; shift_en = 1'b0;
    word = 1'b0; we = 1'b0; wdata = '0; mem_rdata = '0; mem_r = 1'b0; resp_ready = 1'b0;

    for (int i = 0; i < 65536; i++) begin
      rb = 16'($urandom);
      bus_mem[i] = rb[7:0];
      mdl_mem[i] = rb[7:0];
    end
    poke(16'h3004, 8'hEF); poke(16'h3005, 8'hBE);
    poke(16'h3000, 8'h12); poke(16'h3001, 8'h80);
    poke(16'h0000, 8'h34); poke(16'h0001, 8'h12);

    //          b        o        sh    wd    w     wdt      dly mem   addr     mask   wdata    data     flt    lat
    tbl[0]  = '{16'h3000, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0000, 2, 1'b1, 16'h3004, 2'b11, 16'h0000, 16'hBEEF, 2'b00, 5};
    tbl[1]  = '{16'h3001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h3000, 2'b10, 16'h0000, 16'hFF80, 2'b00, 3};
    tbl[2]  = '{16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h3000, 2'b01, 16'h0000, 16'h0012, 2'b00, 3};
    tbl[3]  = '{16'h4000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h00A5, 1, 1'b1, 16'h4000, 2'b10, 16'hA5A5, 16'h0000, 2'b00, 4};
    tbl[4]  = '{16'h3003, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b01, 2};
    tbl[5]  = '{16'hFFFE, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 2'b11, 16'h0000, 16'h1234, 2'b00, 3};
    tbl[6]  = '{16'h5000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hCAFE, 0, 1'b1, 16'h4FFE, 2'b11, 16'hCAFE, 16'h0000, 2'b00, 3};
    tbl[7]  = '{16'h4FFE, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 16'h4FFE, 2'b11, 16'h0000, 16'hCAFE, 2'b00, 4};
    tbl[8]  = '{16'h4001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h4000, 2'b10, 16'h0000, 16'hFFA5, 2'b00, 3};
    tbl[9]  = '{16'h3004, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 99, 1'b1, 16'h3004, 2'b11, 16'h0000, 16'h0000, 2'b10, 6};
    tbl[10] = '{16'h3004, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3, 1'b1, 16'h3004, 2'b11, 16'h0000, 16'hBEEF, 2'b00, 6};
    tbl[11] = '{16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h1177, 0, 1'b1, 16'h0000, 2'b01, 16'h7777, 16'h0000, 2'b00, 3};
    tbl[12] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 2'b11, 16'h0000, 16'h1277, 2'b00, 3};
    tbl[13] = '{16'h4FFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 0, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b01, 2};
    tbl[14] = '{16'h4FFE, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h4FFE, 2'b11, 16'h0000, 16'hCAFE, 2'b00, 3};

    tick(); tick();
    chk("reset.ready_valid", {req_ready, resp_valid, mem_en, mem_we}, 4'b1000);
    chk("reset.mem_bus", {mem_addr, mem_wdata, mem_wmask}, 34'h0);
    chk("reset.resp", {resp_data, resp_fault}, 18'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("vec%0d", i);
      model(tbl[i].b, tbl[i].o, tbl[i].sh, tbl[i].wd, tbl[i].w, tbl[i].wdt, tbl[i].dly,
            e_mem, e_addr, e_mask, e_wdata, e_data, e_fault, e_lat);
      run_txn(tbl[i].b, tbl[i].o, tbl[i].sh, tbl[i].wd, tbl[i].w, tbl[i].wdt, tbl[i].dly);
      compare_obs(tag, tbl[i].e_mem, tbl[i].e_addr, tbl[i].e_mask, tbl[i].e_wdata, tbl[i].w,
                  tbl[i].e_data, tbl[i].e_fault, tbl[i].e_lat);
      finish_resp(tag, 0);
    end

    // Timeout response held under backpressure with a competing request.
    run_txn(16'h3004, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 99);
    chk("stall.fault", ob_fault, 2'b10);
    chk("stall.mem_cycles", ob_mcyc, TMO);
    base = 16'h3000; offset = 16'h0000; shift_en = 1'b0; word = 1'b1; we = 1'b0;
    req_valid = 1'b1;
    finish_resp("stall", 5);
    req_valid = 1'b0;

    // Reset asserted while the memory transaction is outstanding.
    base = 16'h3004; offset = 16'h0000; shift_en = 1'b0; word = 1'b1; we = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid.in_mem", mem_en, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid.state", {mem_en, resp_valid, req_ready}, 3'b001);
    chk("rst_mid.addr", mem_addr, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_valid || mem_en) seen = 1'b1;
    end
    chk("rst_mid.dropped", seen, 1'b0);
    run_txn(16'h3004, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
    compare_obs("rst_recover", 1'b1, 16'h3004, 2'b11, 16'h0000, 1'b0, 16'hBEEF, 2'b00, 3);
    finish_resp("rst_recover", 0);

    for (int n = 0; n < 200; n++) begin
      rb   = (($urandom_range(0, 3) == 0) ? 16'hFFE0 : 16'h6000) + 16'($urandom_range(0, 31));
      ro   = 16'($urandom_range(0, 31)) - 16'd16;
      rsh  = 1'($urandom);
      rwd  = 1'($urandom);
      rw   = 1'($urandom);
      rwdt = 16'($urandom);
      rdly = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, TMO - 1);
      tag  = $sformatf("rnd%0d", n);
      model(rb, ro, rsh, rwd, rw, rwdt, rdly, e_mem, e_addr, e_mask, e_wdata, e_data, e_fault, e_lat);
      run_txn(rb, ro, rsh, rwd, rw, rwdt, rdly);
      compare_obs(tag, e_mem, e_addr, e_mask, e_wdata, rw, e_data, e_fault, e_lat);
      finish_resp(tag, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
